// File: rtl/fetch_ctrl_if.sv
// Control bundle between the fetch sequencer and its neighbours: hazard and
// branch fields from ID/EX, the IMEM ready line, and the IF_stage control word.
interface fetch_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
);
   logic [DATA_WIDTH-1:0] boot_add;
   logic                  imem_ready;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  ex_branch_taken;
   logic [DATA_WIDTH-1:0] ex_branch_target;
   logic                  stall;
   logic                  flush;
   logic                  pc_sel;
   logic [DATA_WIDTH-1:0] pc_dest;
   logic                  id_ex_bubble;
   logic [31:0]           stall_cnt;

   // Pipeline side: supplies hazard/branch/memory status, consumes control.
   modport master (
      output boot_add, imem_ready, ex_mem_read, ex_rd, id_rs1, id_rs2,
             ex_branch_taken, ex_branch_target,
      input  stall, flush, pc_sel, pc_dest, id_ex_bubble, stall_cnt
   );

   // Sequencer side.
   modport slave (
      input  boot_add, imem_ready, ex_mem_read, ex_rd, id_rs1, id_rs2,
             ex_branch_taken, ex_branch_target,
      output stall, flush, pc_sel, pc_dest, id_ex_bubble, stall_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: boot redirect after reset, EX branch redirects,
// load-use bubbles and IMEM wait states merged into one IF control word.
module fetch_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int BOOT_WAIT    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   fetch_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_WAIT, S_BOOT, S_RUN, S_FLUSH, S_MEMW} state_t;

   localparam int WAIT_W  = (BOOT_WAIT > 1)    ? $clog2(BOOT_WAIT)    : 1;
   localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(BOOT_WAIT - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic [31:0]           stall_cnt_q;

   logic                  load_use;
   logic                  go_flush;
   logic                  stall, flush, pc_sel, id_ex_bubble;
   logic [DATA_WIDTH-1:0] pc_dest;

   assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

   // State register, sequencing counters, pending redirect and stall counter.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT;
         wait_cnt_q  <= WAIT_LOAD;
         flush_cnt_q <= '0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   // Next-state: boot countdown, redirect entry into FLUSH, IMEM wait tracking.
   // NOTE: every combinational output gets a default first so no path through
   // the case statement can infer a latch.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      go_flush    = 1'b0;
      case (state_q)
         S_WAIT: begin
            if (wait_cnt_q == '0) state_d = S_BOOT;
            else                  wait_cnt_d = wait_cnt_q - WAIT_W'(1);
         end
         S_BOOT: go_flush = 1'b1;
         S_RUN: begin
            if (bus.ex_branch_taken) go_flush = 1'b1;
            else if (!bus.imem_ready) state_d = S_MEMW;
         end
         S_FLUSH: begin
            if (flush_cnt_q <= FLUSH_W'(1)) state_d = S_RUN;
            else                           flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
         end
         S_MEMW: begin
            if (!bus.imem_ready) begin
               // Youngest taken branch seen while waiting owns the redirect.
               if (bus.ex_branch_taken) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = bus.ex_branch_target;
               end
            end else begin
               pend_d = 1'b0;
               if (bus.ex_branch_taken || pend_q) go_flush = 1'b1;
               else                               state_d  = S_RUN;
            end
         end
         default: state_d = S_WAIT;
      endcase
      if (go_flush) begin
         flush_cnt_d = FLUSH_LOAD;
         state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
      end
   end

   // Output word: decoded from state plus same-cycle EX/IMEM inputs.
   always_comb begin
      stall        = 1'b0;
      flush        = 1'b0;
      pc_sel       = 1'b0;
      pc_dest      = '0;
      id_ex_bubble = 1'b0;
      case (state_q)
         S_WAIT: stall = 1'b1;
         S_BOOT: begin
            pc_sel  = 1'b1;
            pc_dest = bus.boot_add;
            flush   = 1'b1;
         end
         S_RUN: begin
            if (bus.ex_branch_taken) begin
               pc_sel       = 1'b1;
               pc_dest      = bus.ex_branch_target;
               flush        = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (!bus.imem_ready) begin
               stall = 1'b1;
            end else if (load_use) begin
               stall        = 1'b1;
               id_ex_bubble = 1'b1;
            end
         end
         S_FLUSH: flush = 1'b1;
         S_MEMW: begin
            if (!bus.imem_ready) begin
               stall        = 1'b1;
               id_ex_bubble = bus.ex_branch_taken;
            end else if (bus.ex_branch_taken) begin
               pc_sel       = 1'b1;
               pc_dest      = bus.ex_branch_target;
               flush        = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (pend_q) begin
               pc_sel  = 1'b1;
               pc_dest = pend_tgt_q;
               flush   = 1'b1;
            end
         end
         default: stall = 1'b1;
      endcase
   end

   assign bus.stall        = stall;
   assign bus.flush        = flush;
   assign bus.pc_sel       = pc_sel;
   assign bus.pc_dest      = pc_dest;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver predicts each cycle's control word
// from a flag-based reference model, a monitor compares what the DUT shows.
module tb_fetch_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int FC = 2;
   localparam int BW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

   fetch_ctrl #(
      .DATA_WIDTH(DW), .REG_ADDR_W(AW), .FLUSH_CYCLES(FC), .BOOT_WAIT(BW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic        stall, flush, pc_sel, bub;
      logic [31:0] dest, cnt;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_no   = 0;

   // Stimulus variables
   logic        v_rst_n = 1'b0;
   logic [31:0] v_boot  = 32'h100;
   logic        v_ready = 1'b1;
   logic        v_mr    = 1'b0;
   logic [4:0]  v_rd = '0, v_rs1 = '0, v_rs2 = '0;
   logic        v_br    = 1'b0;
   logic [31:0] v_tgt   = '0;
   logic        forced  = 1'b0;

   // Reference model: cycles of boot stall left, boot redirect due, flush
   // cycles left, waiting on IMEM, and a remembered redirect.
   int          m_boot_left;
   bit          m_boot_due;
   int          m_flush_left;
   bit          m_blocked;
   bit          m_pend;
   logic [31:0] m_pend_addr;
   logic [31:0] m_cnt;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input int cyc);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_boot_left  = BW;
      m_boot_due   = 1'b1;
      m_flush_left = 0;
      m_blocked    = 1'b0;
      m_pend       = 1'b0;
      m_pend_addr  = '0;
      m_cnt        = '0;
   endtask

   task automatic redirect(inout exp_t e, input logic [31:0] addr);
      e.pc_sel     = 1'b1;
      e.dest       = addr;
      e.flush      = 1'b1;
      m_flush_left = FC - 1;
   endtask

   task automatic model_cycle(output exp_t e);
      bit hazard;
      e = '{stall: 1'b0, flush: 1'b0, pc_sel: 1'b0, bub: 1'b0,
            dest: '0, cnt: '0, cyc: cyc_no};
      if (!v_rst_n) begin
         model_reset();
         e.stall = 1'b1;
         return;
      end
      hazard = v_mr && (v_rd != 0) && (v_rd == v_rs1 || v_rd == v_rs2);
      e.cnt = m_cnt;
      if (m_boot_left > 0) begin
         e.stall = 1'b1;
         m_boot_left--;
      end else if (m_boot_due) begin
         redirect(e, v_boot);
         m_boot_due = 1'b0;
      end else if (m_flush_left > 0) begin
         e.flush = 1'b1;
         m_flush_left--;
      end else if (m_blocked) begin
         if (!v_ready) begin
            e.stall = 1'b1;
            if (v_br) begin
               e.bub       = 1'b1;
               m_pend      = 1'b1;
               m_pend_addr = v_tgt;
            end
         end else begin
            m_blocked = 1'b0;
            if (v_br) begin
               redirect(e, v_tgt);
               e.bub = 1'b1;
            end else if (m_pend) begin
               redirect(e, m_pend_addr);
            end
            m_pend = 1'b0;
         end
      end else begin
         if (v_br) begin
            redirect(e, v_tgt);
            e.bub = 1'b1;
         end else if (!v_ready) begin
            e.stall   = 1'b1;
            m_blocked = 1'b1;
         end else if (hazard) begin
            e.stall = 1'b1;
            e.bub   = 1'b1;
         end
      end
      if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
   endtask

   // One cycle: drive at the falling edge, predict, queue the expectation.
   task automatic tick(input bit force_sat = 1'b0);
      exp_t e;
      @(negedge clk);
      if (forced) begin
         release dut.stall_cnt_q;
         forced = 1'b0;
      end
      rst_n                = v_rst_n;
      bus.boot_add         = v_boot;
      bus.imem_ready       = v_ready;
      bus.ex_mem_read      = v_mr;
      bus.ex_rd            = v_rd;
      bus.id_rs1           = v_rs1;
      bus.id_rs2           = v_rs2;
      bus.ex_branch_taken  = v_br;
      bus.ex_branch_target = v_tgt;
      if (force_sat) begin
         force dut.stall_cnt_q = 32'hFFFF_FFFE;
         forced = 1'b1;
         m_cnt  = 32'hFFFF_FFFE;
      end
      model_cycle(e);
      sb_q.push_back(e);
      cyc_no++;
   endtask

   task automatic quiet();
      v_ready = 1'b1; v_mr = 1'b0; v_br = 1'b0;
      v_rd = '0; v_rs1 = '0; v_rs2 = '0;
   endtask

   // Monitor: compares the DUT's control word against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("stall",        {31'd0, bus.stall},        {31'd0, e.stall},  e.cyc);
            check("flush",        {31'd0, bus.flush},        {31'd0, e.flush},  e.cyc);
            check("pc_sel",       {31'd0, bus.pc_sel},       {31'd0, e.pc_sel}, e.cyc);
            check("pc_dest",      bus.pc_dest,               e.dest,            e.cyc);
            check("id_ex_bubble", {31'd0, bus.id_ex_bubble}, {31'd0, e.bub},    e.cyc);
            check("stall_cnt",    bus.stall_cnt,             e.cnt,             e.cyc);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc_no);
      $fatal(1, "time limit");
   end

   initial begin
      model_reset();
      quiet();
      // Reset held: stall only
      v_rst_n = 1'b0;
      repeat (3) tick();
      // Boot: 4 stall cycles, redirect to 0x100, one flush-only cycle, RUN
      v_rst_n = 1'b1;
      v_boot  = 32'h100;
      repeat (8) tick();
      // Load-use hazard on rs2, then ex_rd = 0 (no hazard)
      v_mr = 1'b1; v_rd = 5'd5; v_rs1 = 5'd1; v_rs2 = 5'd5;
      tick();
      quiet(); tick();
      v_mr = 1'b1; v_rd = 5'd0; v_rs1 = 5'd0; v_rs2 = 5'd0;
      tick();
      quiet(); tick();
      // Branch overrides a simultaneous load-use hazard
      v_br = 1'b1; v_tgt = 32'h2040; v_mr = 1'b1; v_rd = 5'd7; v_rs1 = 5'd7;
      tick();
      quiet(); repeat (3) tick();
      // IMEM wait 3 cycles, branch on the 2nd, redirect on the ready cycle
      v_ready = 1'b0; tick();
      v_br = 1'b1; v_tgt = 32'h300; tick();
      v_br = 1'b0; tick();
      v_ready = 1'b1; repeat (4) tick();
      // Reset during MEMW with a pending redirect
      v_ready = 1'b0; tick();
      v_br = 1'b1; v_tgt = 32'h300; tick();
      v_br = 1'b0; v_rst_n = 1'b0; tick();
      v_ready = 1'b1; tick();
      v_rst_n = 1'b1; v_boot = 32'h0000_0400;
      repeat (10) tick();
      // Stall counter saturation
      quiet(); tick(1'b1);
      v_ready = 1'b0; repeat (3) tick();
      v_ready = 1'b1; repeat (3) tick();
      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         v_rst_n = ($urandom_range(0, 149) != 0);
         v_boot  = $urandom() & 32'hFFFF_FFFC;
         v_ready = ($urandom_range(0, 3) != 0);
         v_br    = ($urandom_range(0, 5) == 0);
         v_tgt   = $urandom() & 32'hFFFF_FFFC;
         v_mr    = $urandom_range(0, 1);
         v_rd    = 5'($urandom_range(0, 3));
         v_rs1   = 5'($urandom_range(0, 3));
         v_rs2   = 5'($urandom_range(0, 3));
         tick();
      end
      quiet(); v_rst_n = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      #4;
      check("scoreboard_drain", sb_q.size(), 32'd0, cyc_no);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
